// File: rtl/sn_encoder_if.sv
// Stream-request and stochastic-bit signals for sn_encoder.
// The slave side is the encoder. The master side is whoever issues starts and consumes bits.
interface sn_encoder_if;
    logic       i_start_udc;
    logic [3:0] i_x_udc;
    logic       i_en_udc;
    logic       o_sn_bit;
    logic       o_valid;
    logic       o_busy;
    logic       o_done;

    modport slave (
        input  i_start_udc, i_x_udc, i_en_udc,
        output o_sn_bit, o_valid, o_busy, o_done
    );

    modport master (
        output i_start_udc, i_x_udc, i_en_udc,
        input  o_sn_bit, o_valid, o_busy, o_done
    );
endinterface

// File: rtl/sn_encoder.sv
// Bipolar stochastic-number encoder: turns a signed 4-bit value into a 16*N_PERIODS bit stream.
// The ones density of that stream is (x+8)/16.
//
// state | meaning
// IDLE  | waiting for i_start_udc; the value and the generator are loaded on the accepting edge
// RUN   | one stream bit per enabled cycle; stalls while i_en_udc is low
// DONE  | single-cycle o_done pulse, then back to IDLE
module sn_encoder #(
    parameter logic [3:0] SEED      = 4'b0001,
    parameter int         N_PERIODS = 1
) (
    input  logic          i_clk_udc,
    input  logic          i_rst_udc,
    sn_encoder_if.slave   bus
);
    localparam int             LEN  = 16 * N_PERIODS;
    localparam int             CW   = $clog2(LEN);
    localparam logic [CW-1:0]  LAST = CW'(LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_r, state_nxt;
    logic [3:0]    lfsr_r, lfsr_nxt, lfsr_w;
    logic [3:0]    x_r, x_nxt, u;
    logic [CW-1:0] cnt_r, cnt_nxt;
    logic          fire;

    // The zero-detect term splices state 0 into the maximal-length LFSR, giving a period of 16.
    assign lfsr_w = {lfsr_r[2:0], lfsr_r[3] ^ lfsr_r[2] ^ (lfsr_r[2:0] == 3'b000)};
    assign u      = {~x_r[3], x_r[2:0]};
    assign fire   = (state_r == RUN) && bus.i_en_udc;

    assign bus.o_valid  = fire;
    assign bus.o_sn_bit = fire && (lfsr_r < u);
    assign bus.o_busy   = (state_r != IDLE);
    assign bus.o_done   = (state_r == DONE);

    always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
        if (i_rst_udc) begin
            state_r <= IDLE;
            lfsr_r  <= SEED;
            cnt_r   <= '0;
            x_r     <= '0;
        end else begin
            state_r <= state_nxt;
            lfsr_r  <= lfsr_nxt;
            cnt_r   <= cnt_nxt;
            x_r     <= x_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        lfsr_nxt  = lfsr_r;
        cnt_nxt   = cnt_r;
        x_nxt     = x_r;
        case (state_r)
            IDLE: begin
                if (bus.i_start_udc) begin
                    state_nxt = RUN;
                    x_nxt     = bus.i_x_udc;
                    lfsr_nxt  = SEED;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                if (bus.i_en_udc) begin
                    lfsr_nxt = lfsr_w;
                    cnt_nxt  = cnt_r + CW'(1);
                    if (cnt_r == LAST) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sn_encoder.sv
// Scoreboard bench for sn_encoder: expected bits and stream totals are queued by the driver.
// Separate monitors pop and compare them whenever the encoders present output.
module tb_sn_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sn_encoder_if b1();
    sn_encoder_if b2();

    sn_encoder #(.SEED(4'b0001), .N_PERIODS(1)) dut1 (.i_clk_udc(clk), .i_rst_udc(rst), .bus(b1));
    sn_encoder #(.SEED(4'b0001), .N_PERIODS(4)) dut2 (.i_clk_udc(clk), .i_rst_udc(rst), .bus(b2));

    // Generator order from SEED=1, worked out by hand from the feedback equation.
    int seq [16] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 0};

    int checks = 0;
    int errors = 0;

    bit exp_q [$];
    int exp2_q [$];
    int ones1 = 0, valid1 = 0, done_cnt1 = 0;
    int ones2 = 0, net2 = 0, done_cnt2 = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_stream(input int x);
        for (int i = 0; i < 16; i++) exp_q.push_back(seq[i] < (x + 8));
    endtask

    // Bit-level scoreboard for the N_PERIODS=1 encoder.
    always @(negedge clk) begin
        if (b1.o_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb1_unexpected_bit", 1, 0);
            end else begin
                chk("sb1_bit", int'(b1.o_sn_bit), int'(exp_q.pop_front()));
            end
            ones1  += int'(b1.o_sn_bit);
            valid1 += 1;
        end else if (b1.o_sn_bit) begin
            chk("sb1_bit_without_valid", 1, 0);
        end
        if (b1.o_done) done_cnt1++;
    end

    // Stream-total scoreboard for the N_PERIODS=4 encoder, with an up/down counter.
    always @(negedge clk) begin
        if (b2.o_valid) begin
            ones2 += int'(b2.o_sn_bit);
            net2  += b2.o_sn_bit ? 1 : -1;
        end
        if (b2.o_done) begin
            done_cnt2++;
            if (exp2_q.size() == 0) begin
                chk("sb2_unexpected_done", 1, 0);
            end else begin
                int x;
                x = exp2_q.pop_front();
                chk($sformatf("sb2_ones_x%0d", x), ones2, 4 * (x + 8));
                chk($sformatf("sb2_net_x%0d", x), net2, 8 * x);
            end
            ones2 = 0;
            net2  = 0;
        end
    end

    // Called at posedge+1; leaves the caller at posedge+1 just after the start edge.
    task automatic start1(input int x, input bit hold);
        ones1  = 0;
        valid1 = 0;
        b1.i_start_udc = 1'b1;
        b1.i_x_udc     = 4'(x);
        @(posedge clk); #1;
        if (!hold) b1.i_start_udc = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the start edge; en is low for cycles st_lo..st_hi.
    task automatic run1(input int st_lo, input int st_hi, input int chg_c, input int chg_x,
                        output int done_at, output int busy_n, output int stall_valid);
        done_at = 0; busy_n = 0; stall_valid = 0;
        for (int c = 1; c <= 80; c++) begin
            b1.i_en_udc = (c >= st_lo && c <= st_hi) ? 1'b0 : 1'b1;
            if (c == chg_c) b1.i_x_udc = 4'(chg_x);
            @(negedge clk);
            if (b1.o_busy) busy_n++;
            if (c >= st_lo && c <= st_hi && b1.o_valid) stall_valid++;
            if (b1.o_done) begin
                done_at = c;
                break;
            end
            @(posedge clk); #1;
        end
        if (done_at == 0) chk("run1_timeout", 0, 1);
        b1.i_en_udc = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int done_at, busy_n, stall_valid, dbefore;
        b1.i_start_udc = 1'b0; b1.i_x_udc = 4'd0; b1.i_en_udc = 1'b1;
        b2.i_start_udc = 1'b0; b2.i_x_udc = 4'd0; b2.i_en_udc = 1'b1;

        #1;
        chk("reset_outputs", int'({b1.o_sn_bit, b1.o_valid, b1.o_busy, b1.o_done}), 0);
        chk("reset_outputs2", int'({b2.o_sn_bit, b2.o_valid, b2.o_busy, b2.o_done}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // x=+7: fifteen ones, the lone zero where the generator sits at 15.
        push_stream(7);
        start1(7, 0);
        run1(0, -1, 0, 0, done_at, busy_n, stall_valid);
        chk("x7_done_cycle", done_at, 17);
        chk("x7_busy_cycles", busy_n, 17);
        chk("x7_valid_count", valid1, 16);
        chk("x7_ones", ones1, 15);

        // x=-8: all zeros.
        push_stream(-8);
        start1(-8, 0);
        run1(0, -1, 0, 0, done_at, busy_n, stall_valid);
        chk("xm8_ones", ones1, 0);
        chk("xm8_done_cycle", done_at, 17);

        // x=0: eight ones, first bit 1.
        push_stream(0);
        start1(0, 0);
        run1(0, -1, 0, 0, done_at, busy_n, stall_valid);
        chk("x0_ones", ones1, 8);

        // Start held high, x changed mid-stream: the stream stays at x=3; a restart happens only from IDLE.
        push_stream(3);
        start1(3, 1);
        run1(0, -1, 6, -5, done_at, busy_n, stall_valid);
        chk("hold_done_cycle", done_at, 17);
        chk("hold_ones", ones1, 11);
        push_stream(-5);
        @(negedge clk);
        chk("hold_idle_gap_busy", int'(b1.o_busy), 0);
        chk("hold_idle_gap_valid", int'(b1.o_valid), 0);
        ones1 = 0; valid1 = 0;
        @(posedge clk); #1;
        b1.i_start_udc = 1'b0;
        run1(0, -1, 0, 0, done_at, busy_n, stall_valid);
        chk("restart_done_cycle", done_at, 17);
        chk("restart_ones", ones1, 3);

        // Three stalled cycles mid-stream.
        push_stream(-3);
        start1(-3, 0);
        run1(6, 8, 0, 0, done_at, busy_n, stall_valid);
        chk("stall_valid_low", stall_valid, 0);
        chk("stall_done_cycle", done_at, 20);
        chk("stall_valid_count", valid1, 16);
        chk("stall_ones", ones1, 5);

        // Asynchronous reset at bit 5, then replay from bit 0.
        push_stream(0);
        dbefore = done_cnt1;
        start1(0, 0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_outputs", int'({b1.o_sn_bit, b1.o_valid, b1.o_busy, b1.o_done}), 0);
        chk("midrst_bits_before", valid1, 5);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_no_done", done_cnt1, dbefore);
        push_stream(0);
        start1(0, 0);
        run1(0, -1, 0, 0, done_at, busy_n, stall_valid);
        chk("midrst_replay_done", done_at, 17);
        chk("midrst_replay_ones", ones1, 8);

        chk("sb1_leftover", exp_q.size(), 0);
        chk("sb1_done_pulses", done_cnt1, 7);

        // N_PERIODS=4 over every input value.
        for (int x = -8; x <= 7; x++) begin
            bit seen;
            seen = 1'b0;
            exp2_q.push_back(x);
            b2.i_start_udc = 1'b1;
            b2.i_x_udc     = 4'(x);
            @(posedge clk); #1;
            b2.i_start_udc = 1'b0;
            for (int c = 0; c < 100 && !seen; c++) begin
                @(negedge clk);
                if (b2.o_done) seen = 1'b1;
            end
            if (!seen) chk($sformatf("n4_timeout_x%0d", x), 0, 1);
            @(posedge clk); #1;
        end
        chk("sb2_leftover", exp2_q.size(), 0);
        chk("sb2_done_pulses", done_cnt2, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
